// File: rtl/z_multdiv_seq.sv
// z_multdiv_seq: sequencer for an iterative multiply/divide datapath.
// A start request moves the FSM through LOAD (one cycle), RUN (N_ITER cycles)
// and DONE (one cycle, result-valid pulse). All outputs are registered.
// N_ITER is legal in the range 2..32; iter is 5 bits wide.
// Optional build macro: DIV_ZERO_EARLY_EN. When it is defined, a divide whose
// divisor was zero at the start edge skips RUN and finishes straight after LOAD.
module z_multdiv_seq #(
    parameter int unsigned N_ITER = 32
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ctrl_mult,
    input  logic       ctrl_div,
    input  logic       divisor_zero,
    output logic       load,
    output logic       step_ena,
    output logic [4:0] iter,
    output logic       op_is_div,
    output logic       busy,
    output logic       data_ready,
    output logic       data_exception
);

    localparam int unsigned ITER_W = 5;
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              dz;
    logic              dz_nxt;
    logic              op_nxt;
    logic [ITER_W-1:0] iter_nxt;
    logic              load_nxt;
    logic              step_nxt;
    logic              busy_nxt;
    logic              ready_nxt;
    logic              exc_nxt;

    // State register plus registered copies of every output and latched flag.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state          <= S_IDLE;
            dz             <= 1'b0;
            op_is_div      <= 1'b0;
            iter           <= '0;
            load           <= 1'b0;
            step_ena       <= 1'b0;
            busy           <= 1'b0;
            data_ready     <= 1'b0;
            data_exception <= 1'b0;
        end else begin
            state          <= state_nxt;
            dz             <= dz_nxt;
            op_is_div      <= op_nxt;
            iter           <= iter_nxt;
            load           <= load_nxt;
            step_ena       <= step_nxt;
            busy           <= busy_nxt;
            data_ready     <= ready_nxt;
            data_exception <= exc_nxt;
        end
    end

    // Next state, latched operation info and the output values for the next cycle.
    always_comb begin
        state_nxt = state;
        dz_nxt    = dz;
        op_nxt    = op_is_div;
        iter_nxt  = '0;

        case (state)
            S_IDLE: begin
                // Multiply wins when both requests arrive together.
                if (ctrl_mult || ctrl_div) begin
                    state_nxt = S_LOAD;
                    op_nxt    = ~ctrl_mult;
                    dz_nxt    = ~ctrl_mult & divisor_zero;
                end
            end
            S_LOAD: begin
`ifdef DIV_ZERO_EARLY_EN
                if (op_is_div && dz) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_RUN;
                end
`else
                state_nxt = S_RUN;
`endif
            end
            S_RUN: begin
                if (iter == ITER_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    iter_nxt = iter + ITER_W'(1);
                end
            end
            S_DONE: begin
                // Requests seen here are dropped, not queued.
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        load_nxt  = (state_nxt == S_LOAD);
        step_nxt  = (state_nxt == S_RUN);
        busy_nxt  = (state_nxt == S_LOAD) || (state_nxt == S_RUN);
        ready_nxt = (state_nxt == S_DONE);
        exc_nxt   = ready_nxt & dz_nxt;
    end

endmodule

// File: tb/tb_z_multdiv_seq.sv
// tb_z_multdiv_seq: self-checking bench for z_multdiv_seq.
// Honors DIV_ZERO_EARLY_EN when the build defines it.
`timescale 1ns/1ps
module tb_z_multdiv_seq;

`ifdef DIV_ZERO_EARLY_EN
    localparam bit EARLY    = 1'b1;
    localparam int DZ_READY = 2;
    localparam int DZ_STEPS = 0;
    localparam int DZ2_RDY  = 2;
    localparam int DZ2_STP  = 0;
`else
    localparam bit EARLY    = 1'b0;
    localparam int DZ_READY = 34;
    localparam int DZ_STEPS = 32;
    localparam int DZ2_RDY  = 4;
    localparam int DZ2_STP  = 2;
`endif
    localparam int N = 32;

    logic       clk = 1'b0;
    logic       clrn = 1'b1;
    logic       ctrl_mult = 1'b0, ctrl_div = 1'b0, divisor_zero = 1'b0;
    logic       load, step_ena, op_is_div, busy, data_ready, data_exception;
    logic [4:0] iter;

    logic       m2 = 1'b0, d2 = 1'b0, dz2 = 1'b0;
    logic       load2, step2, op2, busy2, ready2, exc2;
    logic [4:0] iter2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    z_multdiv_seq #(.N_ITER(32)) dut (
        .clk(clk), .clrn(clrn), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .divisor_zero(divisor_zero), .load(load), .step_ena(step_ena), .iter(iter),
        .op_is_div(op_is_div), .busy(busy), .data_ready(data_ready),
        .data_exception(data_exception)
    );

    z_multdiv_seq #(.N_ITER(2)) dut2 (
        .clk(clk), .clrn(clrn), .ctrl_mult(m2), .ctrl_div(d2),
        .divisor_zero(dz2), .load(load2), .step_ena(step2), .iter(iter2),
        .op_is_div(op2), .busy(busy2), .data_ready(ready2),
        .data_exception(exc2)
    );

    typedef struct {
        logic m;
        logic d;
        logic dz0;
        logic dz1;
        bit   inject;
        int   ready;
        int   steps;
        logic op;
        logic exc;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int id, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got=%0d expected=%0d", nm, id, got, exp);
        end
    endtask

    function automatic logic [10:0] outs32();
        return {load, step_ena, iter, op_is_div, busy, data_ready, data_exception};
    endfunction

    // Start one operation on the 32-iteration instance and check its whole timeline.
    task automatic do_op(input int id, input vec_t v);
        int   loads = 0, first_load = -1, steps = 0, readies = 0, rc = 0;
        int   bad_iter = 0, bad_busy = 0, bad_excl = 0;
        logic exc_seen = 1'b0, op_seen = 1'b0;
        ctrl_mult = v.m; ctrl_div = v.d; divisor_zero = v.dz0;
        tick();
        ctrl_mult = 1'b0; ctrl_div = 1'b0; divisor_zero = v.dz1;
        for (int k = 1; k <= v.ready + 2 && k <= 60; k++) begin
            if (k == 1) op_seen = op_is_div;
            if (load) begin
                loads++;
                if (first_load < 0) first_load = k;
            end
            if (step_ena) begin
                if (steps == 0 && k != 2) bad_iter++;
                if (iter != 5'(k - 2)) bad_iter++;
                steps++;
            end else if (iter != 5'd0) begin
                bad_iter++;
            end
            if (data_ready) begin
                readies++;
                rc = k;
                exc_seen = data_exception;
            end
            if (busy != (k < v.ready)) bad_busy++;
            if (int'(load) + int'(step_ena) + int'(data_ready) > 1) bad_excl++;
            ctrl_div = v.inject && ((step_ena && iter == 5'd9) || data_ready);
            tick();
        end
        ctrl_div = 1'b0;
        chk("load_count", id, loads, 1);
        chk("load_cycle", id, first_load, 1);
        chk("step_count", id, steps, v.steps);
        chk("ready_count", id, readies, 1);
        chk("ready_cycle", id, rc, v.ready);
        chk("exception", id, int'(exc_seen), int'(v.exc));
        chk("op_is_div", id, int'(op_seen), int'(v.op));
        chk("iter_seq", id, bad_iter, 0);
        chk("busy", id, bad_busy, 0);
        chk("exclusive", id, bad_excl, 0);
    endtask

    initial begin
        int   k, rc, steps, found;
        int   ph;
        logic mop, mdz, rm, rd, rz;
        int   len;
        logic [10:0] exp_v;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 34, 32, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 34, 32, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 34, 32, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, DZ_READY, DZ_STEPS, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 34, 32, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DZ_READY, DZ_STEPS, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 34, 32, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 34, 32, 1'b1, 1'b0};

        // Asynchronous reset before any clock edge.
        #1 clrn = 1'b0;
        #2;
        chk("reset_outs", 0, int'(outs32()), 0);
        chk("reset_outs2", 0, int'({load2, step2, iter2, op2, busy2, ready2, exc2}), 0);
        ctrl_mult = 1'b1;
        tick();
        tick();
        chk("reset_hold", 0, int'(outs32()), 0);

        // First start is taken at the first edge with clrn high.
        @(negedge clk);
        clrn = 1'b1;
        tick();
        ctrl_mult = 1'b0;
        chk("first_start_load", 0, int'(load), 1);
        rc = 0;
        for (k = 1; k <= 60 && rc == 0; k++) begin
            if (data_ready) rc = k;
            else tick();
        end
        chk("first_start_ready", 0, rc, 34);
        tick();
        chk("first_start_idle", 0, int'(busy), 0);

        for (int i = 0; i < 8; i++) do_op(i, tbl[i]);

        // Start held through DONE is dropped; held into IDLE it is accepted.
        ctrl_mult = 1'b1;
        tick();
        ctrl_mult = 1'b0;
        found = 0;
        for (k = 0; k < 60 && found == 0; k++) begin
            if (data_ready) found = 1;
            else tick();
        end
        chk("done_reached", 0, found, 1);
        ctrl_mult = 1'b1;
        tick();
        chk("done_start_ignored", 0, int'({load, busy}), 0);
        tick();
        ctrl_mult = 1'b0;
        chk("idle_start_taken", 0, int'(load), 1);
        found = 0;
        for (k = 0; k < 60 && found == 0; k++) begin
            if (data_ready) found = 1;
            tick();
        end
        chk("idle_start_done", 0, found, 1);

        // Reset asserted in the middle of RUN.
        ctrl_mult = 1'b1;
        tick();
        ctrl_mult = 1'b0;
        found = 0;
        for (k = 0; k < 40 && found == 0; k++) begin
            if (step_ena && iter == 5'd15) found = 1;
            else tick();
        end
        chk("reached_iter15", 0, found, 1);
        #2 clrn = 1'b0;
        #1;
        chk("midreset_outs", 0, int'(outs32()), 0);
        tick();
        tick();
        chk("midreset_hold", 0, int'(outs32()), 0);
        @(negedge clk);
        clrn = 1'b1;
        found = 0;
        for (k = 0; k < 40; k++) begin
            tick();
            if (data_ready) found++;
        end
        chk("midreset_no_ready", 0, found, 0);
        do_op(100, tbl[0]);

        // Two-iteration instance.
        d2 = 1'b1; dz2 = 1'b0;
        tick();
        d2 = 1'b0;
        steps = 0; rc = 0;
        for (k = 1; k <= 8; k++) begin
            if (step2) steps++;
            if (ready2 && rc == 0) begin
                rc = k;
                chk("n2_exc", 0, int'(exc2), 0);
                chk("n2_op", 0, int'(op2), 1);
            end
            tick();
        end
        chk("n2_steps", 0, steps, 2);
        chk("n2_ready", 0, rc, 4);
        d2 = 1'b1; dz2 = 1'b1;
        tick();
        d2 = 1'b0; dz2 = 1'b0;
        steps = 0; rc = 0;
        for (k = 1; k <= 8; k++) begin
            if (step2) steps++;
            if (ready2 && rc == 0) begin
                rc = k;
                chk("n2dz_exc", 1, int'(exc2), 1);
            end
            tick();
        end
        chk("n2dz_steps", 1, steps, DZ2_STP);
        chk("n2dz_ready", 1, rc, DZ2_RDY);

        // Random requests against a cycle-count model of the operation.
        ph = 0; mop = op_is_div; mdz = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rm = ($urandom_range(0, 7) == 0);
            rd = ($urandom_range(0, 5) == 0);
            rz = 1'($urandom_range(0, 1));
            ctrl_mult = rm; ctrl_div = rd; divisor_zero = rz;
            len = (EARLY && mop && mdz) ? 2 : N + 2;
            if (ph == 0) begin
                if (rm || rd) begin
                    ph  = 1;
                    mop = !rm;
                    mdz = !rm && rz;
                end
            end else if (ph >= len) begin
                ph = 0;
            end else begin
                ph++;
            end
            len = (EARLY && mop && mdz) ? 2 : N + 2;
            tick();
            exp_v[10]  = (ph == 1);
            exp_v[9]   = (len != 2) && ph >= 2 && ph <= N + 1;
            exp_v[8:4] = exp_v[9] ? 5'(ph - 2) : 5'd0;
            exp_v[3]   = mop;
            exp_v[2]   = ph >= 1 && ph < len;
            exp_v[1]   = (ph != 0) && (ph == len);
            exp_v[0]   = exp_v[1] && mdz;
            chk("random_outs", c, int'(outs32()), int'(exp_v));
        end
        ctrl_mult = 1'b0; ctrl_div = 1'b0; divisor_zero = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
